sha256_message_scheduler: RTL and testbench

//  Consumes the 512-bit padded block from the pre-processing stage and streams the
//  64-word SHA-256 message schedule W[0..63], one 32-bit word per cycle, to the

---
 rtl/sha256_message_scheduler.sv | 86 ++++++++
 tb/tb_sha256_message_scheduler.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_message_scheduler.sv
// SHA-256 message scheduler: streams W[0..63] from a 16-word sliding window.
// SHA256_SCHED_OVERLAP_EN: accept the next block during the W63 handshake.
module sha256_message_scheduler (
  input  logic         clk_i,
  input  logic         reset_n_i,
  input  logic [511:0] block_i,
  input  logic         v_i,
  output logic         ready_o,
  output logic [31:0]  w_o,
  output logic [5:0]   t_o,
  output logic         v_o,
  input  logic         ready_i
);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]  r_state;
  logic [31:0] r_win [16];
  logic [5:0]  r_t;

  logic        w_run;
  logic        w_load;
  logic        w_step;
  logic        w_last;
  logic [31:0] w_nxt;

  function automatic logic [31:0] f_s0(input logic [31:0] x);
    return {x[6:0], x[31:7]}
         ^ {x[17:0], x[31:18]}
         ^ {3'b0, x[31:3]};
  endfunction

  function automatic logic [31:0] f_s1(input logic [31:0] x);
    return {x[16:0], x[31:17]}
         ^ {x[18:0], x[31:19]}
         ^ {10'b0, x[31:10]};
  endfunction

  assign w_run  = (r_state == S_RUN);
  assign w_step = w_run & ready_i;
  assign w_last = w_step & (r_t == 6'd63);

`ifdef SHA256_SCHED_OVERLAP_EN
  assign ready_o = ~w_run | w_last;
`else
  assign ready_o = ~w_run;
`endif

  assign w_load = v_i & ready_o;
  assign w_nxt  = f_s1(r_win[14]) + r_win[9]
                + f_s0(r_win[1]) + r_win[0];

  assign v_o = w_run;
  assign w_o = r_win[0];
  assign t_o = r_t;

  // A load wins over the final step so overlapped blocks restart at t=0
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_state <= S_IDLE;
      r_t     <= 6'd0;
      for (int i = 0; i < 16; i++) begin
        r_win[i] <= 32'd0;
      end
    end else if (w_load) begin
      r_state <= S_RUN;
      r_t     <= 6'd0;
      for (int i = 0; i < 16; i++) begin
        r_win[i] <= block_i[32*i +: 32];
      end
    end else if (w_step) begin
      for (int i = 0; i < 15; i++) begin
        r_win[i] <= r_win[i+1];
      end
      r_win[15] <= w_nxt;
      if (w_last) begin
        r_state <= S_IDLE;
        r_t     <= 6'd0;
      end else begin
        r_t <= r_t + 6'd1;
      end
    end
  end

endmodule

// File: tb/tb_sha256_message_scheduler.sv
// Bench for sha256_message_scheduler against an array-based SHA-256 schedule model.
// Build with +define+SHA256_SCHED_OVERLAP_EN to check the zero-bubble variant.
module tb_sha256_message_scheduler;

  logic         clk;
  logic         reset_n_i;
  logic [511:0] block_i;
  logic         v_i;
  logic         ready_o;
  logic [31:0]  w_o;
  logic [5:0]   t_o;
  logic         v_o;
  logic         ready_i;

  int npass = 0;
  int nfail = 0;
  int ntot  = 0;

  logic [31:0]  exp_w [64];
  logic [31:0]  got_w [64];
  logic [511:0] abc;
  logic [511:0] blk;

`ifdef SHA256_SCHED_OVERLAP_EN
  localparam int GAP = 1;
  localparam bit OVL = 1'b1;
`else
  localparam int GAP = 2;
  localparam bit OVL = 1'b0;
`endif

  sha256_message_scheduler dut (
    .clk_i     (clk),
    .reset_n_i (reset_n_i),
    .block_i   (block_i),
    .v_i       (v_i),
    .ready_o   (ready_o),
    .w_o       (w_o),
    .t_o       (t_o),
    .v_o       (v_o),
    .ready_i   (ready_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] expv);
    ntot++;
    assert (obs === expv) npass++;
    else begin
      nfail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  // Textbook schedule: W[t] = s1(W[t-2]) + W[t-7] + s0(W[t-15]) + W[t-16]
  task automatic build(input logic [511:0] b);
    logic [31:0] s0, s1;
    for (int i = 0; i < 16; i++) exp_w[i] = b[32*i +: 32];
    for (int i = 16; i < 64; i++) begin
      s0 = ror(exp_w[i-15], 7) ^ ror(exp_w[i-15], 18) ^ (exp_w[i-15] >> 3);
      s1 = ror(exp_w[i-2], 17) ^ ror(exp_w[i-2], 19) ^ (exp_w[i-2] >> 10);
      exp_w[i] = s1 + exp_w[i-7] + s0 + exp_w[i-16];
    end
  endtask

  task automatic rand_blk(output logic [511:0] b);
    for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
  endtask

  task automatic load(input logic [511:0] b);
    logic [511:0] junk;
    @(negedge clk);
    block_i = b;
    v_i = 1'b1;
    chk("ready_o_at_load", ready_o, 1);
    @(posedge clk);
    #1;
    v_i = 1'b0;
    rand_blk(junk);
    block_i = junk;
  endtask

  // Stream one loaded block; check every valid cycle against the model
  task automatic stream(input bit bp, input bit noise, input int stall);
    int k, cyc, st;
    logic rdy;
    logic [511:0] nb;
    k = 0;
    cyc = 0;
    st = stall;
    while (k < 64 && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      if (st > 0) begin
        rdy = 1'b0;
        st--;
      end else begin
        rdy = bp ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      ready_i = rdy;
      if (noise && k < 60) begin
        rand_blk(nb);
        block_i = nb;
        v_i = 1'b1;
      end else begin
        v_i = 1'b0;
      end
      #1;
      chk("v_o_run", v_o, 1);
      chk("t_o_run", t_o, 64'(k));
      chk("w_o_run", w_o, exp_w[k]);
      chk("ready_o_run", ready_o, OVL && k == 63 && rdy);
      if (v_o && rdy) begin
        got_w[k] = w_o;
        k++;
      end
    end
    chk("handshakes", 64'(k), 64);
    v_i = 1'b0;
    @(negedge clk);
    chk("v_o_after", v_o, 0);
    chk("ready_o_after", ready_o, 1);
  endtask

  initial begin
    int f63, s0c, n;
    reset_n_i = 1'b0;
    v_i = 1'b0;
    ready_i = 1'b0;
    block_i = '0;
    abc = '0;
    abc[31:0] = 32'h61626380;
    abc[511:480] = 32'h00000018;

    repeat (2) @(negedge clk);
    chk("rst_ready_o", ready_o, 1);
    chk("rst_v_o", v_o, 0);
    chk("rst_w_o", w_o, 0);
    chk("rst_t_o", t_o, 0);
    reset_n_i = 1'b1;

    // abc block, no backpressure
    build(abc);
    load(abc);
    stream(1'b0, 1'b0, 0);
    chk("abc_w0", got_w[0], 32'h61626380);
    chk("abc_w15", got_w[15], 32'h00000018);
    chk("abc_w16", got_w[16], 32'h61626380);
    chk("abc_w17", got_w[17], 32'h000F0000);

    // all-zero block
    build('0);
    load('0);
    stream(1'b0, 1'b0, 0);
    chk("zero_w63", got_w[63], 0);

    // v_i held high: measure W63 -> next W0 spacing
    @(negedge clk);
    block_i = '0;
    v_i = 1'b1;
    ready_i = 1'b1;
    f63 = -1;
    s0c = -1;
    for (int c = 0; c < 200 && s0c < 0; c++) begin
      @(negedge clk);
      if (v_o && t_o == 6'd63 && f63 < 0) f63 = c;
      else if (f63 >= 0 && v_o && t_o == 6'd0) s0c = c;
    end
    chk("b2b_found", 64'(s0c >= 0), 1);
    chk("b2b_gap", 64'(s0c - f63), 64'(GAP));
    v_i = 1'b0;
    n = 0;
    while (v_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("b2b_drain", v_o, 0);

    // backpressure on abc
    build(abc);
    load(abc);
    stream(1'b1, 1'b0, 0);
    chk("bp_w17", got_w[17], 32'h000F0000);

    // reset mid-block at t=20
    load(abc);
    ready_i = 1'b1;
    n = 0;
    while (!(v_o && t_o == 6'd20) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("reach_t20", t_o, 20);
    reset_n_i = 1'b0;
    #1;
    chk("arst_v_o", v_o, 0);
    chk("arst_t_o", t_o, 0);
    chk("arst_w_o", w_o, 0);
    chk("arst_ready_o", ready_o, 1);
    #2;
    reset_n_i = 1'b1;
    @(negedge clk);
    chk("post_rst_v_o", v_o, 0);
    rand_blk(blk);
    build(blk);
    load(blk);
    stream(1'b0, 1'b0, 0);

    // v_i noise during RUN must be ignored
    build(abc);
    load(abc);
    stream(1'b1, 1'b1, 0);
    rand_blk(blk);
    build(blk);
    load(blk);
    stream(1'b0, 1'b0, 0);

    // long stall on W0
    rand_blk(blk);
    build(blk);
    load(blk);
    stream(1'b0, 1'b0, 100);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
